// File: rtl/watchdog_supervisor_pkg.sv
// Shared types and constants for the watchdog supervisor: FSM state encoding,
// cfg/sts bit positions and the default cycle counts (125 MHz clock).
package watchdog_supervisor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_FAULT    = 2'd3
    } sup_state_t;

    // supervisor_cfg bit positions
    localparam int CFG_WD_EN      = 0;
    localparam int CFG_ALIVE_EN   = 1;
    localparam int CFG_FORCE_RST  = 2;
    localparam int CFG_CLR_FAULT  = 3;

    // supervisor_sts bit positions
    localparam int STS_STATE_LSB  = 0;
    localparam int STS_ACK_CAUSE  = 2;
    localparam int STS_ALIVE_CAUSE = 3;
    localparam int STS_WD         = 4;
    localparam int STS_ACK_SYNC   = 5;
    localparam int STS_ALIVE_SYNC = 6;
    localparam int STS_TRIG       = 7;
    localparam int STS_FCNT_LSB   = 8;

    // Default timing at 125 MHz
    localparam int DEF_TOGGLE_PERIOD_CYCLES = 1250000;
    localparam int DEF_ACK_TIMEOUT_CYCLES   = 125000;
    localparam int DEF_ALIVE_TIMEOUT_CYCLES = 15000000;
    localparam int DEF_SYNC_STAGES          = 2;

    // All timing counters share this width; each clears at its terminal value.
    localparam int CNT_W = 25;

endpackage

// File: rtl/watchdog_supervisor_sync_edge.sv
// sync_edge: N-stage flip-flop synchronizer for one asynchronous pin, plus a
// rising-edge strobe built from the synchronized value and its one-cycle delay.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              q_d;

    // Shift the pin through the synchronizer and keep one delayed copy for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            q_d   <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            q_d   <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = chain[STAGES-1] & ~q_d;

endmodule

// File: rtl/watchdog_supervisor.sv
// watchdog_supervisor: drives a toggling watchdog to a remote board, checks the
// echoed reset_ack within a timeout, optionally monitors the remote alive pulse,
// and on failure latches a fault and drives instant_reset to the remote board.
// Optional build macro: SUPERVISOR_ALIVE_MON_EN (alive monitor present).
module watchdog_supervisor
    import watchdog_supervisor_pkg::*;
#(
    parameter int TOGGLE_PERIOD_CYCLES = DEF_TOGGLE_PERIOD_CYCLES,
    parameter int ACK_TIMEOUT_CYCLES   = DEF_ACK_TIMEOUT_CYCLES,
    parameter int ALIVE_TIMEOUT_CYCLES = DEF_ALIVE_TIMEOUT_CYCLES,
    parameter int SYNC_STAGES          = DEF_SYNC_STAGES
) (
    input  logic        clk,
    input  logic        peripheral_aresetn,
    input  logic [7:0]  supervisor_cfg,
    input  logic        reset_ack_in,
    input  logic        alive_signal_in,
    input  logic        master_trigger_in,
    output logic        watchdog_out,
    output logic        instant_reset_out,
    output logic        trigger_out,
    output logic        fault,
    output logic [31:0] supervisor_sts
);

    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(TOGGLE_PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT_CYCLES - 1);

    sup_state_t       state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic             wd_q, wd_d;
    logic             cause_ack_q, cause_ack_d;
    logic             cause_alive_q, cause_alive_d;
    logic [7:0]       fault_cnt_q;
    logic             inst_rst_q, trig_q, fault_q, clr_d1_q;
    logic             ack_sync, trig_sync, alive_sync, alive_to, ack_to, clr_rise;
    logic             unused_ack_rise, unused_trig_rise, unused_cfg;
    logic             run_active;

    sync_edge #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk(clk), .rst_n(peripheral_aresetn), .d(reset_ack_in),
        .q(ack_sync), .rise(unused_ack_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_trig_sync (
        .clk(clk), .rst_n(peripheral_aresetn), .d(master_trigger_in),
        .q(trig_sync), .rise(unused_trig_rise)
    );

    assign unused_cfg = ^supervisor_cfg[7:4];
    assign run_active = (state_q == ST_RUN) || (state_q == ST_WAIT_ACK);
    assign clr_rise   = supervisor_cfg[CFG_CLR_FAULT] & ~clr_d1_q;

`ifdef SUPERVISOR_ALIVE_MON_EN
    localparam logic [CNT_W-1:0] ALIVE_LAST = CNT_W'(ALIVE_TIMEOUT_CYCLES - 1);
    logic             alive_rise, alive_active;
    logic [CNT_W-1:0] alive_cnt_q;

    sync_edge #(.STAGES(SYNC_STAGES)) u_alive_sync (
        .clk(clk), .rst_n(peripheral_aresetn), .d(alive_signal_in),
        .q(alive_sync), .rise(alive_rise)
    );

    assign alive_active = supervisor_cfg[CFG_ALIVE_EN] && run_active;
    assign alive_to     = alive_active && !alive_rise && (alive_cnt_q == ALIVE_LAST);

    // Alive interval counter: held at 0 when inactive, restarts on each alive edge
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn)
            alive_cnt_q <= '0;
        else if (!alive_active || alive_rise || alive_to)
            alive_cnt_q <= '0;
        else
            alive_cnt_q <= alive_cnt_q + 1'b1;
    end
`else
    logic unused_alive;
    assign unused_alive = alive_signal_in ^ supervisor_cfg[CFG_ALIVE_EN] ^ run_active;
    assign alive_sync   = 1'b0;
    assign alive_to     = 1'b0;
`endif

    // Next-state, counter and watchdog-level logic
    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        ack_cnt_d     = ack_cnt_q;
        wd_d          = wd_q;
        cause_ack_d   = cause_ack_q;
        cause_alive_d = cause_alive_q;
        ack_to        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                period_d  = '0;
                ack_cnt_d = '0;
                if (supervisor_cfg[CFG_WD_EN]) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (alive_to) begin
                    state_d       = ST_FAULT;
                    cause_alive_d = 1'b1;
                end else if (!supervisor_cfg[CFG_WD_EN]) begin
                    state_d = ST_IDLE;
                end else if (period_q == PERIOD_LAST) begin
                    wd_d      = ~wd_q;
                    period_d  = '0;
                    ack_cnt_d = '0;
                    state_d   = ST_WAIT_ACK;
                end else begin
                    period_d = period_q + 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                // Period keeps running; the ack timeout is shorter than the period
                period_d  = period_q + 1'b1;
                ack_cnt_d = ack_cnt_q + 1'b1;
                ack_to    = (ack_sync != wd_q) && (ack_cnt_q == ACK_LAST);
                if (ack_to || alive_to) begin
                    state_d       = ST_FAULT;
                    ack_cnt_d     = '0;
                    cause_ack_d   = cause_ack_q | ack_to;
                    cause_alive_d = cause_alive_q | alive_to;
                end else if (!supervisor_cfg[CFG_WD_EN]) begin
                    state_d = ST_IDLE;
                end else if (ack_sync == wd_q) begin
                    state_d = ST_RUN;
                end
            end
            default: begin // ST_FAULT: watchdog frozen so the remote side expires too
                period_d  = '0;
                ack_cnt_d = '0;
                if (clr_rise) begin
                    state_d       = ST_IDLE;
                    cause_ack_d   = 1'b0;
                    cause_alive_d = 1'b0;
                end
            end
        endcase
    end

    // State, counters, causes, saturating fault count and registered outputs
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            state_q       <= ST_IDLE;
            period_q      <= '0;
            ack_cnt_q     <= '0;
            wd_q          <= 1'b0;
            cause_ack_q   <= 1'b0;
            cause_alive_q <= 1'b0;
            fault_cnt_q   <= '0;
            inst_rst_q    <= 1'b0;
            trig_q        <= 1'b0;
            fault_q       <= 1'b0;
            clr_d1_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            ack_cnt_q     <= ack_cnt_d;
            wd_q          <= wd_d;
            cause_ack_q   <= cause_ack_d;
            cause_alive_q <= cause_alive_d;
            if (state_d == ST_FAULT && state_q != ST_FAULT && fault_cnt_q != 8'hFF)
                fault_cnt_q <= fault_cnt_q + 1'b1;
            inst_rst_q    <= (state_q == ST_FAULT) | supervisor_cfg[CFG_FORCE_RST];
            trig_q        <= trig_sync & (state_q != ST_FAULT);
            fault_q       <= (state_q == ST_FAULT);
            clr_d1_q      <= supervisor_cfg[CFG_CLR_FAULT];
        end
    end

    assign watchdog_out      = wd_q;
    assign instant_reset_out = inst_rst_q;
    assign trigger_out       = trig_q;
    assign fault             = fault_q;

    // Status word assembly
    always_comb begin
        supervisor_sts                           = '0;
        supervisor_sts[STS_STATE_LSB +: 2]       = state_q;
        supervisor_sts[STS_ACK_CAUSE]            = cause_ack_q;
        supervisor_sts[STS_ALIVE_CAUSE]          = cause_alive_q;
        supervisor_sts[STS_WD]                   = wd_q;
        supervisor_sts[STS_ACK_SYNC]             = ack_sync;
        supervisor_sts[STS_ALIVE_SYNC]           = alive_sync;
        supervisor_sts[STS_TRIG]                 = trig_q;
        supervisor_sts[STS_FCNT_LSB +: 8]        = fault_cnt_q;
    end

endmodule

// File: tb/tb_watchdog_supervisor.sv
// Self-checking bench for watchdog_supervisor with short timing parameters.
// Build with or without SUPERVISOR_ALIVE_MON_EN; the alive scenario adapts.
module tb_watchdog_supervisor;

  localparam int TOGGLE = 100;
  localparam int ACK_TO = 20;
  localparam int ALIVE_TO = 300;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cfg = 8'h00;
  logic        ack_force = 1'b0;
  logic        loop_en = 1'b0;
  logic        alive_pin = 1'b0;
  logic        trig_pin = 1'b0;
  logic        reset_ack_in;
  logic        watchdog_out, instant_reset_out, trigger_out, fault;
  logic [31:0] sts;
  logic [4:0]  ack_dly = '0;

  int n_cmp = 0;
  int n_err = 0;

  // clock / remote-board loopback model (ack echoes watchdog after 5 cycles)
  always #5 clk = ~clk;
  always @(posedge clk) ack_dly <= {ack_dly[3:0], watchdog_out};
  assign reset_ack_in = loop_en ? ack_dly[4] : ack_force;

  watchdog_supervisor #(
    .TOGGLE_PERIOD_CYCLES(TOGGLE),
    .ACK_TIMEOUT_CYCLES(ACK_TO),
    .ALIVE_TIMEOUT_CYCLES(ALIVE_TO),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .peripheral_aresetn(rst_n),
    .supervisor_cfg(cfg),
    .reset_ack_in(reset_ack_in),
    .alive_signal_in(alive_pin),
    .master_trigger_in(trig_pin),
    .watchdog_out(watchdog_out),
    .instant_reset_out(instant_reset_out),
    .trigger_out(trigger_out),
    .fault(fault),
    .supervisor_sts(sts)
  );

  typedef struct {
    logic [7:0] cfg;
    logic       trig;
    logic       exp_inst;
    logic       exp_trig;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg = 8'h00;
    loop_en = 1'b0;
    ack_force = 1'b0;
    alive_pin = 1'b0;
    trig_pin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string name);
    int n = 0;
    while (sts[1:0] !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {30'b0, sts[1:0]}, {30'b0, st});
  endtask

  initial begin
    vec_t vecs[6];
    int   last_t, toggles, bad_int, fault_cyc, bad_state, first_fault;
    logic saw_run, saw_wait, prev_wd, frozen;

    // ---------------- reset state ----------------
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_wd", {31'b0, watchdog_out}, 0);
    check("rst_inst", {31'b0, instant_reset_out}, 0);
    check("rst_trig", {31'b0, trigger_out}, 0);
    check("rst_fault", {31'b0, fault}, 0);
    check("rst_sts", sts, 0);
    rst_n = 1'b1;

    // ---------------- table: IDLE-state cfg[2] / trigger vectors ----------------
    vecs[0] = '{8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h04, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h04, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'hF4, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      cfg = vecs[i].cfg;
      trig_pin = vecs[i].trig;
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_inst", i), {31'b0, instant_reset_out}, {31'b0, vecs[i].exp_inst});
      check($sformatf("vec%0d_trig", i), {31'b0, trigger_out}, {31'b0, vecs[i].exp_trig});
      check($sformatf("vec%0d_state", i), {30'b0, sts[1:0]}, 0);
    end

    // ---------------- 1: loopback, steady toggling ----------------
    do_reset();
    loop_en = 1'b1;
    cfg = 8'h01;
    @(negedge clk);
    last_t = -1; toggles = 0; bad_int = 0; fault_cyc = 0; bad_state = 0;
    saw_run = 0; saw_wait = 0; prev_wd = watchdog_out;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (watchdog_out !== prev_wd) begin
        if (last_t >= 0 && (i - last_t) != TOGGLE) bad_int++;
        last_t = i;
        toggles++;
        prev_wd = watchdog_out;
      end
      if (fault !== 1'b0) fault_cyc++;
      if (sts[1:0] == 2'd1) saw_run = 1;
      else if (sts[1:0] == 2'd2) saw_wait = 1;
      else bad_state++;
    end
    check("t1_interval", bad_int, 0);
    check("t1_toggles", {31'b0, toggles >= 19}, 1);
    check("t1_nofault", fault_cyc, 0);
    check("t1_states", {30'b0, saw_run, saw_wait}, 3);
    check("t1_badstate", bad_state, 0);

    // ---------------- 2: ack stuck at 0 -> timeout ----------------
    do_reset();
    cfg = 8'h01;
    begin
      int n = 0;
      while (watchdog_out !== 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("t2_wd_rise", {31'b0, watchdog_out}, 1);
    end
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 19) check("t2_state_c19", {30'b0, sts[1:0]}, 2);
      if (c == 20) begin
        check("t2_state_c20", {30'b0, sts[1:0]}, 3);
        check("t2_fault_c20", {31'b0, fault}, 0);
        check("t2_inst_c20", {31'b0, instant_reset_out}, 0);
      end
      if (c == 21) begin
        check("t2_fault_c21", {31'b0, fault}, 1);
        check("t2_inst_c21", {31'b0, instant_reset_out}, 1);
      end
    end
    check("t2_cause_ack", {31'b0, sts[2]}, 1);
    check("t2_cause_alive", {31'b0, sts[3]}, 0);
    check("t2_fcnt", {24'b0, sts[15:8]}, 1);
    trig_pin = 1'b1;
    frozen = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (watchdog_out !== 1'b1) frozen = 1'b0;
    end
    check("t2_wd_frozen", {31'b0, frozen}, 1);
    check("t5_trig_in_fault", {31'b0, trigger_out}, 0);
    check("t2_still_fault", {30'b0, sts[1:0]}, 3);
    trig_pin = 1'b0;

    // ---------------- 3: clear fault, resume with loopback ----------------
    loop_en = 1'b1;
    cfg = 8'h09;
    @(negedge clk);
    check("t3_idle", {30'b0, sts[1:0]}, 0);
    check("t3_causes", {30'b0, sts[3:2]}, 0);
    cfg = 8'h01;
    wait_state(2'd1, 5, "t3_run");
    fault_cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sts[1:0] == 2'd3) fault_cyc++;
    end
    check("t3_nofault", fault_cyc, 0);
    check("t3_fcnt", {24'b0, sts[15:8]}, 1);
    check("t3_fault_low", {31'b0, fault}, 0);

    // ---------------- 5: trigger latency and forced reset in RUN ----------------
    trig_pin = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 2) check("t5_trig_c2", {31'b0, trigger_out}, 0);
      if (c == 3) check("t5_trig_c3", {31'b0, trigger_out}, 1);
    end
    trig_pin = 1'b0;
    cfg = 8'h05;
    @(negedge clk);
    check("t5_force_inst", {31'b0, instant_reset_out}, 1);
    repeat (150) @(negedge clk);
    check("t5_force_running", {31'b0, sts[1:0] == 2'd1 || sts[1:0] == 2'd2}, 1);
    check("t5_force_nofault", {31'b0, fault}, 0);
    cfg = 8'h01;

    // ---------------- 4: alive monitor ----------------
    do_reset();
    loop_en = 1'b1;
    cfg = 8'h03;
    fault_cyc = 0;
    for (int p = 0; p < 4; p++) begin
      alive_pin = 1'b1;
      for (int i = 0; i < 250; i++) begin
        if (i == 5) alive_pin = 1'b0;
        @(negedge clk);
        if (sts[1:0] == 2'd3) fault_cyc++;
      end
    end
    check("t4_nofault_pulsing", fault_cyc, 0);
    alive_pin = 1'b1;
    first_fault = -1;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (c == 4) begin
`ifdef SUPERVISOR_ALIVE_MON_EN
        check("t4_alive_sync", {31'b0, sts[6]}, 1);
`else
        check("t4_alive_sync", {31'b0, sts[6]}, 0);
`endif
      end
      if (c == 5) alive_pin = 1'b0;
      if (sts[1:0] == 2'd3 && first_fault < 0) first_fault = c;
    end
`ifdef SUPERVISOR_ALIVE_MON_EN
    check("t4_fault_time", {31'b0, first_fault >= 301 && first_fault <= 304}, 1);
    check("t4_cause_alive", {31'b0, sts[3]}, 1);
    check("t4_cause_ack", {31'b0, sts[2]}, 0);
`else
    check("t4_no_fault", {31'b0, first_fault < 0}, 1);
    check("t4_cause_alive", {31'b0, sts[3]}, 0);
`endif

    // ---------------- 6: asynchronous reset in WAIT_ACK ----------------
    do_reset();
    cfg = 8'h01;
    wait_state(2'd2, 300, "t6_wait_ack");
    #2 rst_n = 1'b0;
    #1;
    check("t6_wd", {31'b0, watchdog_out}, 0);
    check("t6_inst", {31'b0, instant_reset_out}, 0);
    check("t6_trig", {31'b0, trigger_out}, 0);
    check("t6_fault", {31'b0, fault}, 0);
    check("t6_sts", sts, 0);
    cfg = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_idle", {30'b0, sts[1:0]}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
